// File: rtl/sort_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sort_seq_ctrl
//  Description : Multi-cycle ascending sorter sequencer. Loads N words over a
//                valid/ready input stream, sorts them in place with a single
//                shared unsigned compare-swap unit (one pair per clock, bubble
//                order with early exit), then drains the sorted words over a
//                valid/ready output stream, smallest first.
//  Ports       : clk, rst (async, active-high)
//                in_valid / in_data / in_ready   : input word stream
//                out_valid / out_data / out_ready: sorted output stream
//                busy        : high while sorting or draining
//                sort_cycles : SORT cycles used by the last completed sort
//  Revision    : 1.0 - initial release
// ============================================================================
module sort_seq_ctrl #(
    parameter int W = 32,
    parameter int N = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic         busy,
    output logic [7:0]   sort_cycles
);

    localparam int PW = (N > 2) ? $clog2(N) : 1;
    localparam logic [PW-1:0] C_LAST  = PW'(N - 1);
    localparam logic [PW-1:0] C_JLAST = PW'(N - 2);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SORT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [W-1:0]   r_mem [N];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [PW-1:0]  r_j;
    logic [PW-1:0]  r_pass;
    logic           r_swapped;
    logic [7:0]     r_cnt;
    logic [7:0]     r_sort_cycles;

    logic [PW-1:0]  w_j1;
    logic           w_gt;
    logic           w_pass_end;
    logic           w_sort_done;
    logic           w_load_last;
    logic           w_drain_last;

    // Shared compare-swap unit: strict unsigned greater-than, so equal words
    // are never exchanged.
    assign w_j1       = r_j + 1'b1;
    assign w_gt       = r_mem[r_j] > r_mem[w_j1];
    assign w_pass_end = (r_j == C_JLAST);
    // Early exit when the finishing pass saw no swap (including this cycle's
    // compare); otherwise stop after the last possible pass.
    assign w_sort_done = w_pass_end && (!(r_swapped || w_gt) || (r_pass == C_JLAST));

    assign w_load_last  = in_valid  && (r_wr_ptr == C_LAST);
    assign w_drain_last = out_ready && (r_rd_ptr == C_LAST);

    // out_data is a pure read of the current slot, so it is naturally held
    // while the consumer stalls.
    assign out_data    = r_mem[r_rd_ptr];
    assign sort_cycles = r_sort_cycles;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            ST_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (w_load_last) begin
                    w_state_nxt = ST_SORT;
                end
            end
            ST_SORT: begin
                if (w_sort_done) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                out_valid = 1'b1;
                if (w_drain_last) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            default: begin
                w_state_nxt = ST_LOAD;
            end
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_j           <= '0;
            r_pass        <= '0;
            r_swapped     <= 1'b0;
            r_cnt         <= '0;
            r_sort_cycles <= '0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (in_valid) begin
                        r_mem[r_wr_ptr] <= in_data;
                        if (r_wr_ptr == C_LAST) begin
                            r_wr_ptr  <= '0;
                            r_j       <= '0;
                            r_pass    <= '0;
                            r_swapped <= 1'b0;
                            r_cnt     <= '0;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + 1'b1;
                        end
                    end
                end
                ST_SORT: begin
                    if (w_gt) begin
                        r_mem[r_j]  <= r_mem[w_j1];
                        r_mem[w_j1] <= r_mem[r_j];
                    end
                    r_cnt <= r_cnt + 8'd1;
                    if (w_pass_end) begin
                        if (w_sort_done) begin
                            // Counter has not yet counted this final cycle.
                            r_sort_cycles <= r_cnt + 8'd1;
                        end else begin
                            r_j       <= '0;
                            r_pass    <= r_pass + 1'b1;
                            r_swapped <= 1'b0;
                        end
                    end else begin
                        r_j       <= w_j1;
                        r_swapped <= r_swapped | w_gt;
                    end
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        if (r_rd_ptr == C_LAST) begin
                            r_rd_ptr <= '0;
                        end else begin
                            r_rd_ptr <= r_rd_ptr + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sort_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sort_seq_ctrl
//  Description : Directed self-checking bench for sort_seq_ctrl (W=32, N=6).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sort_seq_ctrl;

    typedef logic [31:0] job_t [6];

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        busy;
    logic [7:0]  sort_cycles;

    int checks;
    int errors;

    sort_seq_ctrl #(.W(32), .N(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .busy        (busy),
        .sort_cycles (sort_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Push six words, one per cycle; returns 1ns after the accepting edge.
    task automatic load_job(input job_t w);
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = w[i];
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // Runs from the edge after the last input until in_ready returns,
    // collecting output words and timing information.
    task automatic run_out(input bit rnd, input bit junk, output job_t got,
                           output int ngot, output int s_wait, output int low_cnt,
                           output bit stable_ok, output bit timeout);
        logic [31:0] prev;
        bit          stalled;
        ngot      = 0;
        s_wait    = -1;
        low_cnt   = 0;
        stable_ok = 1'b1;
        timeout   = 1'b1;
        stalled   = 1'b0;
        prev      = '0;
        for (int i = 0; i < 6; i++) got[i] = '0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (cyc > 0 && in_ready) begin
                timeout = 1'b0;
                break;
            end
            if (!in_ready) low_cnt++;
            if (out_valid && s_wait < 0) s_wait = cyc;
            if (stalled && (!out_valid || out_data !== prev)) stable_ok = 1'b0;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (junk) begin
                in_valid = 1'b1;
                in_data  = 32'hDEAD;
            end
            if (out_valid && out_ready) begin
                if (ngot < 6) got[ngot] = out_data;
                ngot++;
            end
            stalled = out_valid && !out_ready;
            prev    = out_data;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL reset_out_data got %0h exp 0", out_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (sort_cycles !== 8'd0) begin errors++; $display("FAIL reset_sort_cycles got %0d exp 0", sort_cycles); end
    endtask

    task automatic test_descending();
        job_t w, exp, got;
        int ngot, s_wait, low_cnt;
        bit stable_ok, timeout;
        w   = '{32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
        exp = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
        load_job(w);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL desc_busy got %b exp 1", busy); end
        run_out(1'b0, 1'b0, got, ngot, s_wait, low_cnt, stable_ok, timeout);
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL desc_timeout got %b exp 0", timeout); end
        checks++; if (s_wait !== 25) begin errors++; $display("FAIL desc_latency got %0d exp 25", s_wait); end
        checks++; if (low_cnt !== 31) begin errors++; $display("FAIL desc_in_ready_low got %0d exp 31", low_cnt); end
        checks++; if (ngot !== 6) begin errors++; $display("FAIL desc_count got %0d exp 6", ngot); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL desc_word[%0d] got %0h exp %0h", i, got[i], exp[i]); end
        end
        checks++; if (sort_cycles !== 8'd25) begin errors++; $display("FAIL desc_sort_cycles got %0d exp 25", sort_cycles); end
    endtask

    task automatic test_sorted();
        job_t w, got;
        int ngot, s_wait, low_cnt;
        bit stable_ok, timeout;
        w = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
        load_job(w);
        run_out(1'b0, 1'b0, got, ngot, s_wait, low_cnt, stable_ok, timeout);
        checks++; if (s_wait !== 5) begin errors++; $display("FAIL sorted_latency got %0d exp 5", s_wait); end
        checks++; if (low_cnt !== 11) begin errors++; $display("FAIL sorted_in_ready_low got %0d exp 11", low_cnt); end
        checks++; if (ngot !== 6) begin errors++; $display("FAIL sorted_count got %0d exp 6", ngot); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (got[i] !== w[i]) begin errors++; $display("FAIL sorted_word[%0d] got %0h exp %0h", i, got[i], w[i]); end
        end
        checks++; if (sort_cycles !== 8'd5) begin errors++; $display("FAIL sorted_sort_cycles got %0d exp 5", sort_cycles); end
    endtask

    task automatic test_unsigned_dups();
        job_t w, exp, got;
        int ngot, s_wait, low_cnt;
        bit stable_ok, timeout;
        w   = '{32'd7, 32'd3, 32'd7, 32'hFFFFFFFF, 32'd0, 32'd3};
        exp = '{32'd0, 32'd3, 32'd3, 32'd7, 32'd7, 32'hFFFFFFFF};
        load_job(w);
        run_out(1'b0, 1'b0, got, ngot, s_wait, low_cnt, stable_ok, timeout);
        checks++; if (ngot !== 6) begin errors++; $display("FAIL unsigned_count got %0d exp 6", ngot); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL unsigned_word[%0d] got %0h exp %0h", i, got[i], exp[i]); end
        end
    endtask

    task automatic test_backpressure();
        job_t w, exp, got;
        int ngot, s_wait, low_cnt;
        bit stable_ok, timeout;
        w   = '{32'd4, 32'd6, 32'd2, 32'd6, 32'd1, 32'd3};
        exp = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd6, 32'd6};
        load_job(w);
        run_out(1'b1, 1'b0, got, ngot, s_wait, low_cnt, stable_ok, timeout);
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL bp_timeout got %b exp 0", timeout); end
        checks++; if (stable_ok !== 1'b1) begin errors++; $display("FAIL bp_stable got %b exp 1", stable_ok); end
        checks++; if (ngot !== 6) begin errors++; $display("FAIL bp_count got %0d exp 6", ngot); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL bp_word[%0d] got %0h exp %0h", i, got[i], exp[i]); end
        end
    endtask

    task automatic test_back_to_back();
        job_t wa, ea, wb, eb, got;
        int ngot, s_wait, low_cnt;
        bit stable_ok, timeout;
        wa = '{32'd3, 32'd1, 32'd2, 32'd0, 32'd5, 32'd4};
        ea = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
        wb = '{32'd9, 32'd8, 32'd1, 32'd1, 32'd0, 32'd2};
        eb = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd8, 32'd9};
        load_job(wa);
        run_out(1'b0, 1'b1, got, ngot, s_wait, low_cnt, stable_ok, timeout);
        checks++; if (ngot !== 6) begin errors++; $display("FAIL junk_a_count got %0d exp 6", ngot); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (got[i] !== ea[i]) begin errors++; $display("FAIL junk_a_word[%0d] got %0h exp %0h", i, got[i], ea[i]); end
        end
        load_job(wb);
        run_out(1'b0, 1'b0, got, ngot, s_wait, low_cnt, stable_ok, timeout);
        checks++; if (ngot !== 6) begin errors++; $display("FAIL b2b_count got %0d exp 6", ngot); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (got[i] !== eb[i]) begin errors++; $display("FAIL b2b_word[%0d] got %0h exp %0h", i, got[i], eb[i]); end
        end
    endtask

    task automatic test_reset_mid_sort();
        job_t w, exp, got;
        int ngot, s_wait, low_cnt;
        bit stable_ok, timeout;
        w = '{32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
        load_job(w);
        repeat (11) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b exp 1", busy); end
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %b exp 0", out_valid); end
        checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL mid_out_data got %0h exp 0", out_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b exp 0", busy); end
        checks++; if (sort_cycles !== 8'd0) begin errors++; $display("FAIL mid_sort_cycles got %0d exp 0", sort_cycles); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        w   = '{32'd2, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0};
        exp = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd2};
        load_job(w);
        run_out(1'b0, 1'b0, got, ngot, s_wait, low_cnt, stable_ok, timeout);
        checks++; if (ngot !== 6) begin errors++; $display("FAIL post_rst_count got %0d exp 6", ngot); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL post_rst_word[%0d] got %0h exp %0h", i, got[i], exp[i]); end
        end
        checks++; if (sort_cycles !== 8'd15) begin errors++; $display("FAIL post_rst_sort_cycles got %0d exp 15", sort_cycles); end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_descending();
        test_sorted();
        test_unsigned_dups();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_sort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
